// File: rtl/dist_spi_reader_pkg.sv
// dist_spi_reader_pkg: shared state encodings and frame constants for the SSR distribution reader
package dist_spi_reader_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_HOLD = 3'd4
  } state_t;
  localparam logic [7:0] SPI_READ_CMD = 8'h03;
  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;
  localparam int DIST_BITS = 256;
endpackage

// File: rtl/dist_spi_reader_spi_clk_gen.sv
// spi_clk_gen: SPI mode-0 clock divider with rise/fall strobes
//   clk, rst_n : system clock, async active-low reset
//   en         : run the divider; when low the divider and sclk are held at 0
//   sclk       : SPI clock, low for CLK_DIV cycles then high for CLK_DIV cycles
//   rise, fall : one-cycle strobes marking the clk edge at which sclk goes high / low
module spi_clk_gen
  import dist_spi_reader_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);
  logic [7:0] div;
  logic       wrap;
  assign wrap = en && div == 8'(CLK_DIV - 1);
  assign rise = wrap && !sclk;
  assign fall = wrap && sclk;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      div  <= '0;
      sclk <= 1'b0;
    end else begin
      div  <= wrap ? 8'd0 : div + 8'd1;
      sclk <= wrap ? ~sclk : sclk;
    end
  end
endmodule

// File: rtl/dist_spi_reader.sv
// dist_spi_reader: fetches a 32-byte distribution from an external SSR over SPI mode 0
//   clk, rst_n   : system clock, async active-low reset
//   start, addr  : one-cycle fetch request and 24-bit SSR byte address
//   busy, done   : transfer in progress / one-cycle completion pulse
//   dist_data    : 256-bit distribution, first received bit in [255]
//   spi_*        : SPI master pins (sclk, cs_n, mosi, miso)
module dist_spi_reader
  import dist_spi_reader_pkg::*;
#(
  parameter int         CLK_DIV  = 4,
  parameter logic [7:0] READ_CMD = SPI_READ_CMD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [23:0]          addr,
  output logic                 busy,
  output logic                 done,
  output logic [DIST_BITS-1:0] dist_data,
  output logic                 spi_sclk,
  output logic                 spi_cs_n,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);
  localparam int TX_BITS = CMD_BITS + ADDR_BITS;
  state_t               state, nxt;
  logic [8:0]           cnt;
  logic [TX_BITS-1:0]   tx_sr;
  logic [DIST_BITS-1:0] rx_sr;
  logic                 en, rise, fall, fin, take;
  assign en       = state inside {S_CMD, S_ADDR, S_DATA};
  assign take     = state == S_IDLE && start;
  assign busy     = state != S_IDLE;
  assign spi_cs_n = state == S_IDLE;
  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .sclk (spi_sclk),
    .rise (rise),
    .fall (fall)
  );
  // HOLD counts CLK_DIV+1 cycles so the CS hold plus the request cycle
  // give a start-to-done latency of 1 + 576*CLK_DIV + CLK_DIV.
  always_comb begin
    nxt = state;
    fin = 1'b0;
    case (state)
      S_IDLE: nxt = start ? S_CMD : S_IDLE;
      S_CMD:  nxt = fall && cnt == 9'(CMD_BITS - 1) ? S_ADDR : S_CMD;
      S_ADDR: nxt = fall && cnt == 9'(ADDR_BITS - 1) ? S_DATA : S_ADDR;
      S_DATA: nxt = fall && cnt == 9'(DIST_BITS - 1) ? S_HOLD : S_DATA;
      S_HOLD: begin
        fin = cnt == 9'(CLK_DIV);
        nxt = fin ? S_IDLE : S_HOLD;
      end
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end
  // The first MOSI bit is driven at the accepting edge; every later bit
  // is shifted out at the sclk falling edge that ends the previous bit.
  // Zeros shifted in behind the header keep MOSI low through DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      spi_mosi  <= 1'b0;
      done      <= 1'b0;
      dist_data <= '0;
    end else begin
      done <= fin;
      cnt  <= nxt != state ? 9'd0 : (state == S_HOLD || fall) ? cnt + 9'd1 : cnt;
      if (take) begin
        tx_sr    <= {READ_CMD[6:0], addr, 1'b0};
        spi_mosi <= READ_CMD[7];
        rx_sr    <= '0;
      end else if (fall) begin
        tx_sr    <= {tx_sr[TX_BITS-2:0], 1'b0};
        spi_mosi <= tx_sr[TX_BITS-1];
      end
      if (rise && state == S_DATA) rx_sr <= {rx_sr[DIST_BITS-2:0], spi_miso};
      if (fin) dist_data <= rx_sr;
    end
  end
endmodule

// File: tb/tb_dist_spi_reader.sv
// tb_dist_spi_reader: directed table-driven bench for dist_spi_reader with an SSR model
module tb_dist_spi_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic         start1, busy1, done1, sclk1, cs1, mosi1, miso1;
  logic [23:0]  addr1;
  logic [255:0] data1;
  logic         start2, busy2, done2, sclk2, cs2, mosi2, miso2;
  logic [23:0]  addr2;
  logic [255:0] data2;
  dist_spi_reader #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .addr(addr1), .busy(busy1), .done(done1),
    .dist_data(data1), .spi_sclk(sclk1), .spi_cs_n(cs1), .spi_mosi(mosi1), .spi_miso(miso1)
  );
  dist_spi_reader #(.CLK_DIV(2), .READ_CMD(8'h03)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .addr(addr2), .busy(busy2), .done(done2),
    .dist_data(data2), .spi_sclk(sclk2), .spi_cs_n(cs2), .spi_mosi(mosi2), .spi_miso(miso2)
  );
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int dc1 = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done1) dc1++;
  end
  // SSR models: count sclk rises since cs_n fell; header bits are captured from MOSI.
  int          n1 = 0, nz1 = 0, n2 = 0;
  logic [31:0] hdr1 = '0, hdr2 = '0, pat1 = '0;
  logic [4:0]  bi1;
  always @(posedge sclk1 or posedge cs1) begin
    if (cs1) begin
      n1 = 0; hdr1 = '0; nz1 = 0;
    end else begin
      if (n1 < 32) hdr1 = {hdr1[30:0], mosi1};
      else if (mosi1) nz1++;
      n1++;
    end
  end
  assign bi1   = 5'(31 - (n1 % 32));
  assign miso1 = (n1 < 32) ? 1'b1 : pat1[bi1];
  always @(posedge sclk2 or posedge cs2) begin
    if (cs2) begin
      n2 = 0; hdr2 = '0;
    end else begin
      if (n2 < 32) hdr2 = {hdr2[30:0], mosi2};
      n2++;
    end
  end
  assign miso2 = (n2 == 32);
  // protocol checker, sampled once per cycle
  logic ps1 = 0, pm1 = 0, pb1 = 0, ps2 = 0, pm2 = 0, pb2 = 0;
  task automatic proto(input string nm);
    n_fail++;
    $display("FAIL proto %s at cycle %0d", nm, cyc);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (ps1 && sclk1 && mosi1 !== pm1) proto("mosi1_stable_while_sclk_high");
      if (ps2 && sclk2 && mosi2 !== pm2) proto("mosi2_stable_while_sclk_high");
      if (cs1 && sclk1) proto("sclk1_high_with_cs_n_high");
      if (cs2 && sclk2) proto("sclk2_high_with_cs_n_high");
      if (done1 && !pb1) proto("done1_without_prior_busy");
      if (done2 && !pb2) proto("done2_without_prior_busy");
    end
    ps1 = sclk1; pm1 = mosi1; pb1 = busy1;
    ps2 = sclk2; pm2 = mosi2; pb2 = busy2;
  end
  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  // Waits for done1, capturing the MOSI header and bit count as of the last HOLD cycle.
  task automatic wait1(input int c0, input int ghost, output int lat, output logic [31:0] hdr,
                       output int nbits, output int nz, output logic stable);
    logic [255:0] d0;
    int k;
    d0 = data1; k = 0; lat = -1; stable = 1'b1; hdr = '0; nbits = 0; nz = 0;
    while (!done1 && k < 5000) begin
      hdr = hdr1; nbits = n1; nz = nz1;
      if (data1 !== d0) stable = 1'b0;
      @(negedge clk);
      k++;
      start1 = (k == ghost);
      if (k == ghost) addr1 = 24'h123456;
    end
    if (done1) lat = cyc - c0;
    else begin
      n_cmp++; n_fail++;
      $display("FAIL done1_timeout: no done after %0d cycles", k);
    end
  endtask
  task automatic xfer1(input logic [23:0] a, input int ghost, output int lat, output logic [31:0] hdr,
                       output int nbits, output int nz, output logic stable);
    int c0;
    addr1 = a; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; c0 = cyc;
    chk("busy_after_start", busy1, 1'b1);
    chk("csn_after_start", cs1, 1'b0);
    wait1(c0, ghost, lat, hdr, nbits, nz, stable);
  endtask
  typedef struct {
    logic [23:0]  addr;
    logic [31:0]  pat;
    int           ghost;
    logic [31:0]  hdr;
    logic [255:0] data;
  } vec_t;
  vec_t vt[5];
  initial begin
    int lat, nb, nz, k, c0, cd, r0, r1, dc0;
    logic [31:0] hdr;
    logic st;
    vt[0] = '{24'h000100, 32'hDEADBEEF, 0,    32'h03000100, {8{32'hDEADBEEF}}};
    vt[1] = '{24'hFFFFFF, 32'h00000000, 0,    32'h03FFFFFF, 256'h0};
    vt[2] = '{24'hA55A0F, 32'h80000001, 0,    32'h03A55A0F, {8{32'h80000001}}};
    vt[3] = '{24'h000100, 32'hDEADBEEF, 20,   32'h03000100, {8{32'hDEADBEEF}}};
    vt[4] = '{24'h3C0081, 32'h12345678, 1500, 32'h033C0081, {8{32'h12345678}}};
    start1 = 0; start2 = 0; addr1 = '0; addr2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_data", data1, '0);
    chk("rst_sclk", sclk1, 1'b0);
    chk("rst_csn", cs1, 1'b1);
    chk("rst_mosi", mosi1, 1'b0);
    chk("rst_csn2", cs2, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      pat1 = vt[i].pat; dc0 = dc1;
      xfer1(vt[i].addr, vt[i].ghost, lat, hdr, nb, nz, st);
      chk($sformatf("v%0d_latency", i), lat, 2309);
      chk($sformatf("v%0d_mosi_hdr", i), hdr, vt[i].hdr);
      chk($sformatf("v%0d_bit_count", i), nb, 288);
      chk($sformatf("v%0d_mosi_zero_in_data", i), nz, 0);
      chk($sformatf("v%0d_data_stable_before_done", i), st, 1'b1);
      chk($sformatf("v%0d_dist_data", i), data1, vt[i].data);
      chk($sformatf("v%0d_busy_in_done", i), busy1, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_done_width", i), done1, 1'b0);
      chk($sformatf("v%0d_done_pulses", i), dc1 - dc0, 1);
      repeat (2) @(negedge clk);
    end
    // reset during DATA bit 100
    pat1 = 32'hDEADBEEF; addr1 = 24'h000100; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; k = 0;
    while (!(n1 >= 132 && sclk1) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reached_bit100", n1 >= 132 && sclk1, 1'b1);
    dc0 = dc1;
    rst_n = 1'b0;
    #1;
    chk("abort_csn", cs1, 1'b1);
    chk("abort_sclk", sclk1, 1'b0);
    chk("abort_busy", busy1, 1'b0);
    chk("abort_data", data1, '0);
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("abort_no_done", dc1 - dc0, 0);
    rst_n = 1'b1;
    xfer1(24'h000100, 0, lat, hdr, nb, nz, st);
    chk("post_rst_latency", lat, 2309);
    chk("post_rst_hdr", hdr, 32'h03000100);
    chk("post_rst_data", data1, {8{32'hDEADBEEF}});
    @(negedge clk);
    chk("post_rst_done_pulses", dc1 - dc0, 1);
    repeat (2) @(negedge clk);
    // start in the done cycle
    xfer1(24'h000100, 0, lat, hdr, nb, nz, st);
    chk("b2b_first_latency", lat, 2309);
    chk("b2b_csn_in_done", cs1, 1'b1);
    cd = cyc;
    addr1 = 24'h00ABCD; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("b2b_csn_low_again", cs1, 1'b0);
    chk("b2b_busy_again", busy1, 1'b1);
    wait1(cd, 0, lat, hdr, nb, nz, st);
    chk("b2b_done_gap", lat, 2310);
    chk("b2b_second_hdr", hdr, 32'h0300ABCD);
    chk("b2b_second_data", data1, {8{32'hDEADBEEF}});
    repeat (2) @(negedge clk);
    // CLK_DIV=2 instance with a single leading one on MISO
    addr2 = 24'h00C0DE; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; c0 = cyc; k = 0; r0 = 0; r1 = 0;
    while (!sclk2 && k < 100) begin @(negedge clk); k++; end
    r0 = cyc;
    while (sclk2 && k < 100) begin @(negedge clk); k++; end
    while (!sclk2 && k < 100) begin @(negedge clk); k++; end
    r1 = cyc;
    chk("div2_sclk_period", r1 - r0, 4);
    hdr = '0;
    while (!done2 && k < 5000) begin
      hdr = hdr2;
      @(negedge clk);
      k++;
    end
    if (!done2) begin
      n_cmp++; n_fail++;
      $display("FAIL done2_timeout: no done after %0d cycles", k);
    end else begin
      chk("div2_latency", cyc - c0, 1155);
      chk("div2_hdr", hdr, 32'h0300C0DE);
      chk("div2_dist_data", data2, {1'b1, 255'b0});
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dist_spi_reader.md
DIST_SPI_READER -- requirements
Module: dist_spi_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCLK half-period; legal range 2..255.
REQ-002 SHALL have parameter READ_CMD, default 8'h03: SPI read opcode sent first.
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  single-cycle fetch request from the distribution unit.
REQ-006 SHALL have port addr  in  24  external SSR byte address of the 32-byte distribution.
REQ-007 SHALL have port busy  out  1  high from the cycle after start is accepted until done.
REQ-008 SHALL have port done  out  1  one-cycle pulse; dist_data valid from this cycle.
REQ-009 SHALL have port dist_data  out  256  assembled distribution word.
REQ-010 SHALL have port spi_sclk  out  1  SPI clock, mode 0 (idle low).
REQ-011 SHALL have port spi_cs_n  out  1  chip select, active-low.
REQ-012 SHALL have port spi_mosi  out  1  serial data to the SSR.
REQ-013 SHALL have port spi_miso  in  1  serial data from the SSR.

Function
REQ-014 SHALL implement states IDLE, CMD, ADDR, DATA, HOLD.
REQ-015 Transitions SHALL be:
- IDLE->CMD on start.
- CMD->ADDR after 8 bits.
- ADDR->DATA after 24 bits.
- DATA->HOLD after 256 bits.
- HOLD->IDLE after CLK_DIV cycles.
REQ-016 On start in IDLE, the block SHALL latch addr and drive spi_cs_n low and busy high on the next cycle.
REQ-017 Each bit SHALL occupy 2*CLK_DIV cycles: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-018 MOSI SHALL change only while sclk is low, and SHALL be set in the first cycle of each bit.
REQ-019 MISO SHALL be sampled on the clk edge at which sclk goes high.
REQ-020 The serial stream SHALL be MSB-first: READ_CMD[7:0], then addr[23:0], then 256 don't-care bits with MOSI held 0.
REQ-021 The first DATA bit received SHALL land in dist_data[255]; the last SHALL land in dist_data[0].
REQ-022 Assembly SHALL use an internal shift register; dist_data SHALL update only in the done cycle.
REQ-023 In HOLD, sclk SHALL be low and cs_n low; cs_n SHALL rise and done SHALL pulse on the same cycle as the HOLD->IDLE transition.
REQ-024 busy SHALL fall in the done cycle.
REQ-025 Total latency SHALL be exactly 1 + 288*2*CLK_DIV + CLK_DIV cycles from the start-sampled edge to the done edge; 2309 cycles for CLK_DIV=4.
REQ-026 start SHALL be ignored while busy, with no effect on the transfer or addr.
REQ-027 start asserted in the done cycle SHALL be accepted; busy stays high and cs_n returns low on the next cycle.
REQ-028 The bit counter SHALL be 9 bits wide and SHALL reset to 0 on each state change; no wrap inside a state.
REQ-029 The divider counter SHALL be 8 bits wide and SHALL be held at 0 in IDLE.

Reset
REQ-030 On rst_n low, the block SHALL asynchronously force:
- state IDLE;
- busy=0, done=0, dist_data=0;
- spi_sclk=0, spi_cs_n=1, spi_mosi=0;
- all counters and the shift register to 0.
REQ-031 Reset mid-transfer SHALL abort without a done pulse; the SSR sees cs_n deassert immediately.
REQ-032 After rst_n rises, the first start SHALL be accepted on the first rising clk edge.

Structure
REQ-033 The shared package SHALL hold:
- state encodings (3-bit);
- SPI_READ_CMD;
- CMD_BITS=8, ADDR_BITS=24, DIST_BITS=256.
REQ-034 One sub-module, spi_clk_gen, SHALL hold the divider counter and emit sclk plus one-cycle rise/fall strobes.
REQ-035 spi_clk_gen SHALL be enabled only outside IDLE and HOLD.

Verification
REQ-036 Reset then start with addr=24'h000100, CLK_DIV=4, and an SSR model returning 32'hDEADBEEF repeated:
- MOSI shows 03 00 01 00;
- done fires exactly 2309 cycles after start;
- dist_data = {8{32'hDEADBEEF}}.
REQ-037 Second start pulse during busy -> ignored; a single done pulse; MOSI address unchanged.
REQ-038 rst_n low at bit 100 of DATA:
- cs_n=1 and sclk=0 within the same cycle;
- no done pulse;
- dist_data=0;
- a following start completes normally.
REQ-039 start asserted in the done cycle:
- the second transfer begins the next cycle;
- cs_n high for exactly one cycle between transfers;
- two done pulses 2310 cycles apart.
REQ-040 CLK_DIV=2 with an MISO walking-one pattern (only bit 0 of the stream =1):
- dist_data = 256'h1 << 255;
- SCLK period = 4 cycles;
- latency = 1155 cycles.
REQ-041 Protocol checker asserted throughout all tests:
- MOSI stable while sclk is high;
- sclk low whenever cs_n is high;
- done implies the previous-cycle busy was high.
